// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multicycle controller.
// Opcodes, ALU codes, ALU-B source encodings, FSM states, instr classes.
package mc_pkg;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_NAND = 4'b0011;
  localparam logic [3:0] ALU_SHF  = 4'b1010;

  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALUW,
    S_MEM,
    S_WB,
    S_BR,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_R,
    CL_ADDI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_JMP,
    CL_HALT,
    CL_ILL
  } iclass_e;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode -> instruction class.
// Ports: op (IR[15:12]) in; cls (iclass_e) out.
module mc_decode
  import mc_pkg::*;
(
  input  logic [3:0] op,
  output iclass_e    cls
);

  always_comb begin
    cls = CL_ILL;
    unique case (1'b1)
      (op == OP_R):    cls = CL_R;
      (op == OP_ADDI): cls = CL_ADDI;
      (op == OP_LW):   cls = CL_LW;
      (op == OP_SW):   cls = CL_SW;
      (op == OP_BEQ):  cls = CL_BEQ;
      (op == OP_JMP):  cls = CL_JMP;
      (op == OP_HALT): cls = CL_HALT;
      default:         cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle CPU control FSM (IR, status flags, strobes).
// In: clk, rst, instr[15:0], mem_ack, zero.
// Out: mem_req, mem_we, aluctrl[3:0], fctrl[1:0], srca_pc, srcb[1:0],
//      pc_we, ir_we, reg_we, wb_mem, halted, illegal.
// Option MC_CTRL_PERF_EN: adds retired[15:0] instruction counter.
module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        mem_ack,
  input  logic        zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  aluctrl,
  output logic [1:0]  fctrl,
  output logic        srca_pc,
  output logic [1:0]  srcb,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        wb_mem,
  output logic        halted,
  output logic        illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [15:0] retired
`endif
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  iclass_e     cls;

  logic [3:0]  ex_alu;
  logic [1:0]  ex_f;
  logic        ex_pc;
  logic [1:0]  ex_b;

  logic        unused_ir;
  assign unused_ir = ^ir_q[11:6];

  mc_decode u_dec (
    .op  (ir_q[15:12]),
    .cls (cls)
  );

  // ALU setup driven in EXEC and held through ALUW
  always_comb begin
    ex_alu = ALU_ADD;
    ex_f   = 2'b00;
    ex_pc  = 1'b0;
    ex_b   = SRCB_IMM;
    unique case (1'b1)
      (cls == CL_R): begin
        ex_alu = ir_q[3:0];
        ex_f   = ir_q[5:4];
        ex_b   = SRCB_RT;
      end
      (cls == CL_BEQ): begin
        ex_alu = ALU_SUB;
        ex_b   = SRCB_RT;
      end
      (cls == CL_JMP): ex_pc = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    aluctrl   = ALU_ADD;
    fctrl     = 2'b00;
    srca_pc   = 1'b0;
    srcb      = SRCB_RT;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    wb_mem    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        srca_pc = 1'b1;
        srcb    = SRCB_ONE;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (cls)
          CL_HALT: state_d = S_HALT;
          CL_ILL: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC, S_ALUW: begin
        aluctrl = ex_alu;
        fctrl   = ex_f;
        srca_pc = ex_pc;
        srcb    = ex_b;
        if (state_q == S_EXEC) begin
          state_d = S_ALUW;
        end else begin
          unique case (cls)
            CL_R, CL_ADDI: state_d = S_WB;
            CL_LW, CL_SW:  state_d = S_MEM;
            CL_BEQ:        state_d = S_BR;
            CL_JMP: begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == CL_SW);
        if (mem_ack) begin
          if (cls == CL_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_mem  = (cls == CL_LW);
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BR: begin
        srca_pc = 1'b1;
        srcb    = SRCB_IMM;
        pc_we   = zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
    endcase

    // reset silences the bus and strobes in the same cycle it rises
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      aluctrl = ALU_ADD;
      fctrl   = 2'b00;
      srca_pc = 1'b0;
      srcb    = SRCB_RT;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      wb_mem  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

`ifdef MC_CTRL_PERF_EN
  logic [15:0] retired_q, retired_d;

  assign retired_d = retired_q + {15'd0, retire};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed self-checking bench for mc_control.
// Walks each instruction class state by state with hand-derived values.
module tb_mc_control;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        mem_ack;
  logic        zero;
  logic        mem_req, mem_we;
  logic [3:0]  aluctrl;
  logic [1:0]  fctrl;
  logic        srca_pc;
  logic [1:0]  srcb;
  logic        pc_we, ir_we, reg_we, wb_mem;
  logic        halted, illegal;
`ifdef MC_CTRL_PERF_EN
  logic [15:0] retired;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .mem_ack (mem_ack),
    .zero    (zero),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .aluctrl (aluctrl),
    .fctrl   (fctrl),
    .srca_pc (srca_pc),
    .srcb    (srcb),
    .pc_we   (pc_we),
    .ir_we   (ir_we),
    .reg_we  (reg_we),
    .wb_mem  (wb_mem),
    .halted  (halted),
    .illegal (illegal)
`ifdef MC_CTRL_PERF_EN
    ,
    .retired (retired)
`endif
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // FETCH with n wait cycles, then DECODE; returns at the next state
  task automatic do_fetch(input logic [15:0] ins, input int waits);
    instr = ins;
    for (int i = 0; i < waits; i++) begin
      settle();
      chk("f_wait_req", {15'd0, mem_req}, 16'd1);
      chk("f_wait_irwe", {15'd0, ir_we}, 16'd0);
      chk("f_wait_we", {15'd0, mem_we}, 16'd0);
      tick();
    end
    mem_ack = 1'b1;
    settle();
    chk("f_req", {15'd0, mem_req}, 16'd1);
    chk("f_irwe", {15'd0, ir_we}, 16'd1);
    chk("f_pcwe", {15'd0, pc_we}, 16'd1);
    chk("f_srca", {15'd0, srca_pc}, 16'd1);
    chk("f_srcb", {14'd0, srcb}, {14'd0, SRCB_ONE});
    chk("f_alu", {12'd0, aluctrl}, {12'd0, ALU_ADD});
    tick();
    mem_ack = 1'b0;
    settle();
    chk("d_req", {15'd0, mem_req}, 16'd0);
    chk("d_irwe", {15'd0, ir_we}, 16'd0);
    chk("d_pcwe", {15'd0, pc_we}, 16'd0);
    chk("d_regwe", {15'd0, reg_we}, 16'd0);
    tick();
  endtask

  task automatic exec_chk(input string tag, input logic [3:0] alu,
                          input logic [1:0] f, input logic pcsel,
                          input logic [1:0] b);
    settle();
    chk({tag, "_alu"}, {12'd0, aluctrl}, {12'd0, alu});
    chk({tag, "_f"}, {14'd0, fctrl}, {14'd0, f});
    chk({tag, "_srca"}, {15'd0, srca_pc}, {15'd0, pcsel});
    chk({tag, "_srcb"}, {14'd0, srcb}, {14'd0, b});
    chk({tag, "_regwe"}, {15'd0, reg_we}, 16'd0);
    chk({tag, "_req"}, {15'd0, mem_req}, 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    instr = 16'h0000;
    mem_ack = 1'b0;
    zero = 1'b0;
    tick();
    tick();
    settle();
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_irwe", {15'd0, ir_we}, 16'd0);
    chk("rst_pcwe", {15'd0, pc_we}, 16'd0);
    chk("rst_regwe", {15'd0, reg_we}, 16'd0);
    chk("rst_alu", {12'd0, aluctrl}, 16'd0);
    chk("rst_f", {14'd0, fctrl}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_illegal", {15'd0, illegal}, 16'd0);
`ifdef MC_CTRL_PERF_EN
    chk("rst_retired", retired, 16'd0);
`endif
    tick();
    rst = 1'b0;
    settle();
    chk("rel_req", {15'd0, mem_req}, 16'd1);

    // ADDI with two ack-wait cycles; stray ack in EXEC ignored
    do_fetch(16'h1234, 2);
    mem_ack = 1'b1;
    exec_chk("addi_ex", ALU_ADD, 2'b00, 1'b0, SRCB_IMM);
    chk("addi_ack_ign", {15'd0, ir_we}, 16'd0);
    tick();
    mem_ack = 1'b0;
    exec_chk("addi_aw", ALU_ADD, 2'b00, 1'b0, SRCB_IMM);
    tick();
    settle();
    chk("addi_wb", {15'd0, reg_we}, 16'd1);
    chk("addi_wbm", {15'd0, wb_mem}, 16'd0);
    tick();
    settle();
    chk("addi_wb_once", {15'd0, reg_we}, 16'd0);
    chk("addi_next", {15'd0, mem_req}, 16'd1);

    // R-type: aluctrl=IR[3:0]=5, fctrl=IR[5:4]=2
    do_fetch(16'h0025, 0);
    exec_chk("r_ex", 4'h5, 2'h2, 1'b0, SRCB_RT);
    tick();
    exec_chk("r_aw", 4'h5, 2'h2, 1'b0, SRCB_RT);
    tick();
    settle();
    chk("r_wb", {15'd0, reg_we}, 16'd1);
    tick();
    settle();
    chk("r_next", {15'd0, mem_req}, 16'd1);
    chk("r_wb_once", {15'd0, reg_we}, 16'd0);

    // BEQ taken
    do_fetch(16'h4003, 1);
    exec_chk("beq1_ex", ALU_SUB, 2'b00, 1'b0, SRCB_RT);
    tick();
    exec_chk("beq1_aw", ALU_SUB, 2'b00, 1'b0, SRCB_RT);
    chk("beq1_aw_pcwe", {15'd0, pc_we}, 16'd0);
    tick();
    zero = 1'b1;
    settle();
    chk("beq1_br_pcwe", {15'd0, pc_we}, 16'd1);
    chk("beq1_br_srca", {15'd0, srca_pc}, 16'd1);
    chk("beq1_br_srcb", {14'd0, srcb}, {14'd0, SRCB_IMM});
    tick();
    zero = 1'b0;
    settle();
    chk("beq1_next", {15'd0, mem_req}, 16'd1);
`ifdef MC_CTRL_PERF_EN
    chk("retired_3", retired, 16'd3);
`endif

    // BEQ not taken
    do_fetch(16'h4003, 0);
    exec_chk("beq0_ex", ALU_SUB, 2'b00, 1'b0, SRCB_RT);
    tick();
    tick();
    settle();
    chk("beq0_br_pcwe", {15'd0, pc_we}, 16'd0);
    tick();
    settle();
    chk("beq0_next", {15'd0, mem_req}, 16'd1);

    // SW: one idle MEM cycle, then ack
    do_fetch(16'h3001, 0);
    exec_chk("sw_ex", ALU_ADD, 2'b00, 1'b0, SRCB_IMM);
    tick();
    tick();
    settle();
    chk("sw_mem_req", {15'd0, mem_req}, 16'd1);
    chk("sw_mem_we", {15'd0, mem_we}, 16'd1);
    tick();
    settle();
    chk("sw_mem_hold", {15'd0, mem_req}, 16'd1);
    mem_ack = 1'b1;
    settle();
    chk("sw_mem_we2", {15'd0, mem_we}, 16'd1);
    chk("sw_regwe", {15'd0, reg_we}, 16'd0);
    tick();
    mem_ack = 1'b0;
    settle();
    chk("sw_next_we", {15'd0, mem_we}, 16'd0);
    chk("sw_next_req", {15'd0, mem_req}, 16'd1);
    chk("sw_next_regwe", {15'd0, reg_we}, 16'd0);

    // LW
    do_fetch(16'h2001, 0);
    exec_chk("lw_ex", ALU_ADD, 2'b00, 1'b0, SRCB_IMM);
    tick();
    tick();
    mem_ack = 1'b1;
    settle();
    chk("lw_mem_req", {15'd0, mem_req}, 16'd1);
    chk("lw_mem_we", {15'd0, mem_we}, 16'd0);
    tick();
    mem_ack = 1'b0;
    settle();
    chk("lw_wb", {15'd0, reg_we}, 16'd1);
    chk("lw_wbm", {15'd0, wb_mem}, 16'd1);
    tick();
    settle();
    chk("lw_next", {15'd0, mem_req}, 16'd1);

    // JMP
    do_fetch(16'h5010, 0);
    exec_chk("jmp_ex", ALU_ADD, 2'b00, 1'b1, SRCB_IMM);
    chk("jmp_ex_pcwe", {15'd0, pc_we}, 16'd0);
    tick();
    exec_chk("jmp_aw", ALU_ADD, 2'b00, 1'b1, SRCB_IMM);
    chk("jmp_aw_pcwe", {15'd0, pc_we}, 16'd1);
    tick();
    settle();
    chk("jmp_next", {15'd0, mem_req}, 16'd1);
    chk("jmp_pcwe_once", {15'd0, pc_we}, 16'd0);
`ifdef MC_CTRL_PERF_EN
    chk("retired_7", retired, 16'd7);
`endif

    // illegal opcode 7
    do_fetch(16'h7000, 0);
    settle();
    chk("ill_flag", {15'd0, illegal}, 16'd1);
    chk("ill_fetch", {15'd0, mem_req}, 16'd1);
    chk("ill_regwe", {15'd0, reg_we}, 16'd0);

    // reset while waiting in MEM
    do_fetch(16'h2001, 0);
    tick();
    tick();
    settle();
    chk("rm_req", {15'd0, mem_req}, 16'd1);
    chk("ill_sticky", {15'd0, illegal}, 16'd1);
    rst = 1'b1;
    settle();
    chk("rm_req_drop", {15'd0, mem_req}, 16'd0);
    chk("rm_ill_clr", {15'd0, illegal}, 16'd0);
`ifdef MC_CTRL_PERF_EN
    chk("rm_retired", retired, 16'd0);
`endif
    tick();
    rst = 1'b0;
    settle();
    chk("rm_refetch", {15'd0, mem_req}, 16'd1);
    chk("rm_irwe", {15'd0, ir_we}, 16'd0);

`ifdef MC_CTRL_PERF_EN
    force dut.retired_q = 16'hFFFF;
    settle();
    release dut.retired_q;
`endif
    // ADDI after reset (counter wraps when enabled)
    do_fetch(16'h1001, 0);
    tick();
    tick();
    settle();
    chk("addi2_wb", {15'd0, reg_we}, 16'd1);
`ifdef MC_CTRL_PERF_EN
    chk("retired_ffff", retired, 16'hFFFF);
`endif
    tick();
    settle();
`ifdef MC_CTRL_PERF_EN
    chk("retired_wrap", retired, 16'h0000);
`endif
    chk("addi2_next", {15'd0, mem_req}, 16'd1);

    // HALT is terminal and ignores acks
    do_fetch(16'hF000, 0);
    settle();
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_req", {15'd0, mem_req}, 16'd0);
    mem_ack = 1'b1;
    tick();
    settle();
    chk("halt_flag2", {15'd0, halted}, 16'd1);
    chk("halt_req2", {15'd0, mem_req}, 16'd0);
    chk("halt_irwe", {15'd0, ir_we}, 16'd0);
    chk("halt_pcwe", {15'd0, pc_we}, 16'd0);
    mem_ack = 1'b0;
    tick();
    settle();
    chk("halt_flag3", {15'd0, halted}, 16'd1);
    chk("halt_req3", {15'd0, mem_req}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
